// File: rtl/spi_link_pkg.sv
// Constants and state encoding shared by both ends of the framed control-word SPI link.
package spi_link_pkg;

  localparam int LINK_WORDS      = 7;
  localparam int LINK_WORD_BITS  = 16;
  localparam int DEFAULT_CLK_DIV = 12;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_SETUP    = ST_SETUP,
    S_SHIFT_HI = ST_SHIFT_HI,
    S_SHIFT_LO = ST_SHIFT_LO,
    S_HOLD     = ST_HOLD,
    S_GAP      = ST_GAP
  } link_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter; terminal is high while the count sits at zero.
module spi_half_period_timer #(
  parameter int CNT_W = 4
) (
  input  logic             Main_Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             terminal
);

  logic [CNT_W-1:0] count_r;

  // Count down to zero and park there until the next load
  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/control_spi_tx.sv
// Mode-0 SPI master sending one frame of NUM_WORDS words, word 0 and MSB first, CS low for the whole frame.
module control_spi_tx
  import spi_link_pkg::*;
#(
  parameter int NUM_WORDS = LINK_WORDS,
  parameter int WORD_BITS = LINK_WORD_BITS,
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int CS_SETUP  = 4,
  parameter int CS_HOLD   = 4,
  parameter int CS_GAP    = 8
) (
  input  logic                           Main_Clock,
  input  logic                           Reset,
  input  logic                           i_Start,
  input  logic [NUM_WORDS*WORD_BITS-1:0] i_Frame,
  output logic                           o_Busy,
  output logic                           o_Done,
  output logic                           o_SPI_CS,
  output logic                           o_SPI_Clock,
  output logic                           o_SPI_Data
);

  localparam int FRAME_BITS = NUM_WORDS * WORD_BITS;
  localparam int BIT_W      = $clog2(WORD_BITS);
  localparam int WORD_W     = max_int(1, $clog2(NUM_WORDS));
  localparam int IDX_W      = max_int(1, $clog2(FRAME_BITS));
  // The tail low half-period after the last rise is folded into HOLD, so HOLD spans CLK_DIV+CS_HOLD
  localparam int PH_W       = max_int(1, $clog2(max_int(max_int(CS_SETUP, CLK_DIV + CS_HOLD), CS_GAP)));

  link_state_e             state_r;
  logic [FRAME_BITS-1:0]   frame_r;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic [BIT_W-1:0]        next_bit_s;
  logic [WORD_W-1:0]       word_cnt_r;
  logic [WORD_W-1:0]       next_word_s;
  logic [IDX_W-1:0]        next_idx_s;
  logic                    last_bit_s;
  logic                    load_s;
  logic [PH_W-1:0]         load_value_s;
  logic                    terminal_s;

  spi_half_period_timer #(
    .CNT_W(PH_W)
  ) u_timer (
    .Main_Clock(Main_Clock),
    .Reset     (Reset),
    .load      (load_s),
    .load_value(load_value_s),
    .terminal  (terminal_s)
  );

  // Next bit position: bit counter wraps at zero and carries into the word counter
  always_comb begin
    last_bit_s = (bit_cnt_r == {BIT_W{1'b0}}) && (word_cnt_r == WORD_W'(NUM_WORDS - 1));
    if (bit_cnt_r == {BIT_W{1'b0}}) begin
      next_bit_s  = BIT_W'(WORD_BITS - 1);
      next_word_s = word_cnt_r + WORD_W'(1);
    end else begin
      next_bit_s  = bit_cnt_r - BIT_W'(1);
      next_word_s = word_cnt_r;
    end
    next_idx_s = IDX_W'(int'(next_word_s) * WORD_BITS + int'(next_bit_s));
  end

  // Phase timer reload on every state transition
  always_comb begin
    load_s       = 1'b0;
    load_value_s = {PH_W{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (i_Start) begin
          load_s       = 1'b1;
          load_value_s = PH_W'(CS_SETUP - 1);
        end else begin
          load_s       = 1'b0;
        end
      end
      S_SETUP, S_SHIFT_LO: begin
        if (terminal_s) begin
          load_s       = 1'b1;
          load_value_s = PH_W'(CLK_DIV - 1);
        end else begin
          load_s       = 1'b0;
        end
      end
      S_SHIFT_HI: begin
        if (terminal_s && last_bit_s) begin
          load_s       = 1'b1;
          load_value_s = PH_W'(CLK_DIV + CS_HOLD - 1);
        end else if (terminal_s) begin
          load_s       = 1'b1;
          load_value_s = PH_W'(CLK_DIV - 1);
        end else begin
          load_s       = 1'b0;
        end
      end
      S_HOLD: begin
        if (terminal_s) begin
          load_s       = 1'b1;
          load_value_s = PH_W'(CS_GAP - 1);
        end else begin
          load_s       = 1'b0;
        end
      end
      default: begin
        load_s       = 1'b0;
        load_value_s = {PH_W{1'b0}};
      end
    endcase
  end

  // Frame sequencer: phase state, bit/word position and every SPI-facing output
  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      state_r     <= S_IDLE;
      frame_r     <= {FRAME_BITS{1'b0}};
      bit_cnt_r   <= {BIT_W{1'b0}};
      word_cnt_r  <= {WORD_W{1'b0}};
      o_SPI_CS    <= 1'b1;
      o_SPI_Clock <= 1'b0;
      o_SPI_Data  <= 1'b0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_Start) begin
            state_r    <= S_SETUP;
            frame_r    <= i_Frame;
            bit_cnt_r  <= BIT_W'(WORD_BITS - 1);
            word_cnt_r <= {WORD_W{1'b0}};
            o_SPI_CS   <= 1'b0;
            o_SPI_Data <= i_Frame[WORD_BITS-1];
            o_Busy     <= 1'b1;
          end
        end
        S_SETUP, S_SHIFT_LO: begin
          if (terminal_s) begin
            state_r     <= S_SHIFT_HI;
            o_SPI_Clock <= 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (terminal_s) begin
            o_SPI_Clock <= 1'b0;
            if (last_bit_s) begin
              state_r <= S_HOLD;
            end else begin
              state_r    <= S_SHIFT_LO;
              bit_cnt_r  <= next_bit_s;
              word_cnt_r <= next_word_s;
              o_SPI_Data <= frame_r[next_idx_s];
            end
          end
        end
        S_HOLD: begin
          if (terminal_s) begin
            state_r    <= S_GAP;
            bit_cnt_r  <= {BIT_W{1'b0}};
            word_cnt_r <= {WORD_W{1'b0}};
            o_SPI_CS   <= 1'b1;
            o_SPI_Data <= 1'b0;
            o_Done     <= 1'b1;
          end
        end
        S_GAP: begin
          if (terminal_s) begin
            state_r <= S_IDLE;
            o_Busy  <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          o_SPI_CS    <= 1'b1;
          o_SPI_Clock <= 1'b0;
          o_SPI_Data  <= 1'b0;
          o_Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_spi_tx.sv
// Randomized bench for control_spi_tx: a bus monitor decodes frames on SCK rise and measures framing times.
module tb_control_spi_tx;
  import spi_link_pkg::*;

  localparam int NW  = LINK_WORDS;
  localparam int WB  = LINK_WORD_BITS;
  localparam int CD  = 2;
  localparam int CSS = 2;
  localparam int CSH = 2;
  localparam int CSG = 3;
  localparam int FB  = NW * WB;
  localparam int EXP_CS_LOW = CSS + 2 * CD * FB + CSH;

  logic          Main_Clock;
  logic          Reset;
  logic          i_Start;
  logic [FB-1:0] i_Frame;
  logic          o_Busy, o_Done, o_SPI_CS, o_SPI_Clock, o_SPI_Data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  control_spi_tx #(
    .NUM_WORDS(NW), .WORD_BITS(WB), .CLK_DIV(CD),
    .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_GAP(CSG)
  ) dut (
    .Main_Clock (Main_Clock),
    .Reset      (Reset),
    .i_Start    (i_Start),
    .i_Frame    (i_Frame),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_SPI_CS   (o_SPI_CS),
    .o_SPI_Clock(o_SPI_Clock),
    .o_SPI_Data (o_SPI_Data)
  );

  initial begin
    Main_Clock = 1'b0;
    forever #5 Main_Clock = ~Main_Clock;
  end

  always @(posedge Main_Clock) cyc <= cyc + 1;

  // Bus monitor state: a receiver that samples MOSI on SCK rise while CS is low
  logic          prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0, prev_done = 1'b0;
  int            rises = 0, cs_fall_cyc = 0, cs_rise_cyc = -1;
  int            last_rise_cyc = -1000, last_mosi_chg = -1000, stab_err = 0;
  int            done_cnt = 0, done_hi = 0, done_cyc = -1, done_misalign = 0;
  logic [FB-1:0] rx_frame = '0;
  logic [FB-1:0] rx_q[$];
  int            cs_len_q[$];
  int            gap_q[$];
  int            rise_q[$];

  always begin
    @(posedge Main_Clock);
    #2;
    if (prev_cs && !o_SPI_CS) begin
      cs_fall_cyc = cyc;
      rises = 0;
      rx_frame = '0;
      last_mosi_chg = cyc;
      if (cs_rise_cyc >= 0) gap_q.push_back(cyc - cs_rise_cyc);
    end
    if (!o_SPI_CS && !prev_cs && (o_SPI_Data !== prev_mosi)) begin
      if (rises > 0 && (cyc - last_rise_cyc) < CD) stab_err++;
      last_mosi_chg = cyc;
    end
    if (o_SPI_Clock && !prev_sck) begin
      if (o_SPI_CS) stab_err++;
      if ((cyc - last_mosi_chg) < CD) stab_err++;
      if (rises < FB) rx_frame[(rises / WB) * WB + (WB - 1 - (rises % WB))] = o_SPI_Data;
      rises++;
      last_rise_cyc = cyc;
    end
    if (!prev_cs && o_SPI_CS) begin
      cs_rise_cyc = cyc;
      rx_q.push_back(rx_frame);
      cs_len_q.push_back(cyc - cs_fall_cyc);
      rise_q.push_back(rises);
    end
    if (o_Done) begin
      done_hi++;
      if (!prev_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!(o_SPI_CS && !prev_cs)) done_misalign++;
      end
    end
    prev_cs   = o_SPI_CS;
    prev_sck  = o_SPI_Clock;
    prev_mosi = o_SPI_Data;
    prev_done = o_Done;
  end

  function automatic logic [FB-1:0] build_frame(input logic [WB-1:0] w [NW]);
    logic [FB-1:0] f;
    f = '0;
    for (int n = 0; n < NW; n++) f[n*WB +: WB] = w[n];
    return f;
  endfunction

  function automatic logic [FB-1:0] rand_frame();
    logic [WB-1:0] w [NW];
    for (int n = 0; n < NW; n++) w[n] = WB'($urandom);
    return build_frame(w);
  endfunction

  task automatic clear_queues();
    rx_q.delete();
    cs_len_q.delete();
    gap_q.delete();
    rise_q.delete();
  endtask

  // Send one frame from idle and wait until it has completed and Busy has dropped
  task automatic transmit(input logic [FB-1:0] frame, output int start_cyc, output bit ok);
    @(negedge Main_Clock);
    i_Frame   = frame;
    i_Start   = 1'b1;
    start_cyc = cyc;
    @(negedge Main_Clock);
    i_Start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rx_q.size() > 0 && !o_Busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge Main_Clock);
    end
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    Reset = 1'b1; i_Start = 1'b0; i_Frame = '0;
    repeat (3) @(negedge Main_Clock);
    Reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Main_Clock);
      obs = {o_SPI_CS, o_SPI_Clock, o_SPI_Data, o_Busy, o_Done};
      vectors++;
      if (obs !== 5'b10000) begin
        miscompares++;
        $display("FAIL idle_outputs cycle %0d: got cs/sck/mosi/busy/done=%b expected 10000", i, obs);
      end
    end
    vectors++;
    if (rx_q.size() != 0 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL idle_no_frames: got %0d frames %0d dones expected 0 0", rx_q.size(), done_cnt);
    end
  endtask

  task automatic test_directed();
    logic [WB-1:0] w [NW];
    logic [FB-1:0] f;
    int s, d0, dh0, st0;
    bit ok;
    for (int n = 0; n < NW; n++) w[n] = WB'(n + 1);
    f = build_frame(w);
    clear_queues();
    d0 = done_cnt; dh0 = done_hi; st0 = stab_err;
    transmit(f, s, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL directed_timeout: frame did not complete"); end
    vectors++;
    if (rx_q[0] !== f) begin miscompares++; $display("FAIL directed_data: got %h expected %h", rx_q[0], f); end
    vectors++;
    if (rise_q[0] != FB) begin miscompares++; $display("FAIL directed_rises: got %0d expected %0d", rise_q[0], FB); end
    vectors++;
    if (cs_len_q[0] != EXP_CS_LOW) begin miscompares++; $display("FAIL directed_cs_low: got %0d expected %0d", cs_len_q[0], EXP_CS_LOW); end
    vectors++;
    if (done_cyc - s != EXP_CS_LOW + 1) begin miscompares++; $display("FAIL directed_done_cycle: got %0d expected %0d", done_cyc - s, EXP_CS_LOW + 1); end
    vectors++;
    if (done_cnt - d0 != 1 || done_hi - dh0 != 1) begin
      miscompares++; $display("FAIL directed_done_width: got %0d pulses %0d high cycles expected 1 1", done_cnt - d0, done_hi - dh0);
    end
    vectors++;
    if (done_misalign != 0) begin miscompares++; $display("FAIL directed_done_vs_cs: got %0d misaligned expected 0", done_misalign); end
    vectors++;
    if (stab_err != st0) begin miscompares++; $display("FAIL directed_mosi_stability: got %0d violations expected 0", stab_err - st0); end
  endtask

  task automatic test_patterns();
    logic [WB-1:0] w [NW];
    logic [FB-1:0] f;
    int s, st0;
    bit ok;
    w = '{16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A, 16'h8000, 16'h0001, 16'h7FFE};
    f = build_frame(w);
    clear_queues();
    st0 = stab_err;
    transmit(f, s, ok);
    vectors++;
    if (!ok || rx_q[0] !== f) begin miscompares++; $display("FAIL patterns_data: got %h expected %h", rx_q[0], f); end
    vectors++;
    if (stab_err != st0) begin miscompares++; $display("FAIL patterns_mosi_stability: got %0d violations expected 0", stab_err - st0); end
  endtask

  task automatic test_random();
    logic [FB-1:0] f;
    int s;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      f = rand_frame();
      clear_queues();
      transmit(f, s, ok);
      vectors++;
      if (!ok || rx_q[0] !== f) begin miscompares++; $display("FAIL random_data[%0d]: got %h expected %h", k, rx_q[0], f); end
      vectors++;
      if (rise_q[0] != FB || cs_len_q[0] != EXP_CS_LOW) begin
        miscompares++;
        $display("FAIL random_framing[%0d]: got rises %0d cs_low %0d expected %0d %0d", k, rise_q[0], cs_len_q[0], FB, EXP_CS_LOW);
      end
    end
  endtask

  task automatic test_start_mid_frame();
    logic [FB-1:0] f;
    int d0;
    bit ok;
    f = rand_frame();
    clear_queues();
    d0 = done_cnt;
    @(negedge Main_Clock);
    i_Frame = f; i_Start = 1'b1;
    @(negedge Main_Clock);
    i_Start = 1'b0;
    for (int i = 0; i < 1000 && rises < 40; i++) @(negedge Main_Clock);
    i_Frame = {NW{16'h1234}};
    i_Start = 1'b1;
    repeat (3) @(negedge Main_Clock);
    i_Start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rx_q.size() > 0 && !o_Busy) begin ok = 1'b1; break; end
      @(negedge Main_Clock);
    end
    repeat (20) @(negedge Main_Clock);
    vectors++;
    if (!ok || rx_q.size() != 1) begin miscompares++; $display("FAIL midstart_frames: got %0d frames expected 1", rx_q.size()); end
    vectors++;
    if (rx_q[0] !== f) begin miscompares++; $display("FAIL midstart_data: got %h expected %h", rx_q[0], f); end
    vectors++;
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL midstart_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [FB-1:0] f;
    logic [4:0] obs;
    int d0, s;
    bit ok;
    f = rand_frame();
    d0 = done_cnt;
    @(negedge Main_Clock);
    i_Frame = f; i_Start = 1'b1;
    @(negedge Main_Clock);
    i_Start = 1'b0;
    for (int i = 0; i < 1000 && rises < 50; i++) @(negedge Main_Clock);
    Reset = 1'b1;
    @(negedge Main_Clock);
    obs = {o_SPI_CS, o_SPI_Clock, o_SPI_Data, o_Busy, o_Done};
    vectors++;
    if (obs !== 5'b10000) begin miscompares++; $display("FAIL reset_mid_outputs: got cs/sck/mosi/busy/done=%b expected 10000", obs); end
    Reset = 1'b0;
    repeat (10) @(negedge Main_Clock);
    vectors++;
    if (done_cnt != d0 || o_Busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_no_done: got %0d dones busy=%b expected 0 0", done_cnt - d0, o_Busy);
    end
    f = rand_frame();
    clear_queues();
    transmit(f, s, ok);
    vectors++;
    if (!ok || rx_q[0] !== f || rise_q[0] != FB) begin
      miscompares++; $display("FAIL reset_mid_restart: got %h (%0d rises) expected %h (%0d rises)", rx_q[0], rise_q[0], f, FB);
    end
  endtask

  task automatic test_back_to_back();
    logic [FB-1:0] f;
    bit ok;
    f = rand_frame();
    clear_queues();
    @(negedge Main_Clock);
    i_Frame = f; i_Start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rx_q.size() >= 3) begin ok = 1'b1; break; end
      @(negedge Main_Clock);
    end
    i_Start = 1'b0;
    for (int i = 0; i < 1500 && o_Busy; i++) @(negedge Main_Clock);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_timeout: got %0d frames expected 3", rx_q.size()); end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rx_q[k] !== f || rise_q[k] != FB) begin
        miscompares++; $display("FAIL b2b_data[%0d]: got %h (%0d rises) expected %h", k, rx_q[k], rise_q[k], f);
      end
    end
    for (int k = 1; k < 3; k++) begin
      vectors++;
      if (gap_q[k] != CSG + 1) begin miscompares++; $display("FAIL b2b_cs_high[%0d]: got %0d expected %0d", k, gap_q[k], CSG + 1); end
    end
  endtask

  initial begin
    Reset = 1'b1;
    i_Start = 1'b0;
    i_Frame = '0;
    test_reset();
    test_directed();
    test_patterns();
    test_random();
    test_start_mid_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
